// File: rtl/sm_color_pkg.sv
// Shared types, filter/colour codes and the frame classifier for the
// TCS3200-style colour classifier.
package sm_color_pkg;

   typedef enum logic [1:0] {
      COLOR_NONE  = 2'b00,
      COLOR_RED   = 2'b01,
      COLOR_BLUE  = 2'b10,
      COLOR_GREEN = 2'b11
   } color_t;

   localparam logic [1:0] FILT_RED   = 2'b00;
   localparam logic [1:0] FILT_BLUE  = 2'b01;
   localparam logic [1:0] FILT_GREEN = 2'b11;
   localparam logic [1:0] FILT_NONE  = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      GATE,
      CLASSIFY
   } state_t;

   // white: all channels saturated by ambient light; hit: a colour candidate
   typedef struct packed {
      logic   white;
      logic   hit;
      color_t col;
   } class_t;

   function automatic logic [1:0] filt_code(input logic [1:0] ch);
      logic [1:0] code;
      case (ch)
         2'd0:    code = FILT_RED;
         2'd1:    code = FILT_BLUE;
         default: code = FILT_GREEN;
      endcase
      return code;
   endfunction

   function automatic class_t classify(input logic [31:0] r, g, b,
                                       input logic [31:0] white_th, red_max, gb_max);
      class_t res;
      res.white = 1'b0;
      res.hit   = 1'b0;
      res.col   = COLOR_NONE;
      if (r > white_th && g > white_th && b > white_th) begin
         res.white = 1'b1;
      end else if (r > g && r > b && g < red_max && b < red_max) begin
         res.hit = 1'b1;
         res.col = COLOR_RED;
      end else if (b > r && b > g && r < gb_max && g < gb_max) begin
         res.hit = 1'b1;
         res.col = COLOR_BLUE;
      end else if (g > r && g > b && r < gb_max && b < gb_max) begin
         res.hit = 1'b1;
         res.col = COLOR_GREEN;
      end
      return res;
   endfunction

endpackage

// File: rtl/sm_freq_counter.sv
// Synchronises the sensor frequency output, detects rising edges and counts
// them with saturation; cnt_live already includes the current cycle's edge.
module sm_freq_counter #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig,
   input  logic             clr,
   input  logic             cnt_en,
   output logic [CNT_W-1:0] cnt_live
);

   logic             sync1, sync2, prev;
   logic             rise;
   logic [CNT_W-1:0] cnt;

   assign rise = sync2 & ~prev;

   always_comb begin
      cnt_live = cnt;
      if (clr) begin
         cnt_live = '0;
      end else if (cnt_en && rise && cnt != '1) begin
         cnt_live = cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= sig;
         sync2 <= sync1;
         prev  <= sync2;
         cnt   <= cnt_live;
      end
   end

endmodule

// File: rtl/sm_color_classifier.sv
// Sequences the sensor filters, gates per-channel edge counts and classifies
// each completed frame into red/green/blue/none with N-frame confirmation.
module sm_color_classifier
   import sm_color_pkg::*;
#(
   parameter int CNT_W         = 12,
   parameter int GATE_CYCLES   = 256,
   parameter int SETTLE_CYCLES = 4,
   parameter int CONFIRM       = 2,
   parameter int WHITE_TH      = 400,
   parameter int RED_OTHER_MAX = 200,
   parameter int GB_OTHER_MAX  = 300
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cs_out,
   output logic             S0,
   output logic             S1,
   output logic             S2,
   output logic             S3,
   output logic             OE,
   output logic [CNT_W-1:0] red_cnt,
   output logic [CNT_W-1:0] blue_cnt,
   output logic [CNT_W-1:0] green_cnt,
   output logic             meas_valid,
   output logic [1:0]       color
);

   localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX);
   localparam int RUN_W   = $clog2(CONFIRM + 1);

   localparam logic [CNT_W-1:0] WTH  = CNT_W'(WHITE_TH);
   localparam logic [CNT_W-1:0] RMAX = CNT_W'(RED_OTHER_MAX);
   localparam logic [CNT_W-1:0] GMAX = CNT_W'(GB_OTHER_MAX);

   state_t           state, state_nx;
   logic [1:0]       ch, ch_nx;
   logic [TMR_W-1:0] tmr, tmr_nx;
   logic             gate_done, frame_done;
   logic [CNT_W-1:0] cnt_live;
   logic [CNT_W-1:0] hold_r, hold_b, hold_g;
   logic [1:0]       filt;
   class_t           cls;
   color_t           col, col_nx, last, last_nx;
   logic [RUN_W-1:0] run, run_nx;

   assign S0    = 1'b1;
   assign S1    = 1'b0;
   assign OE    = 1'b0;
   assign S2    = filt[1];
   assign S3    = filt[0];
   assign color = col;

   sm_freq_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig      (cs_out),
      .clr      (state != GATE),
      .cnt_en   (state == GATE),
      .cnt_live (cnt_live)
   );

   always_comb begin
      state_nx   = state;
      ch_nx      = ch;
      tmr_nx     = tmr;
      gate_done  = 1'b0;
      frame_done = 1'b0;
      if (!en) begin
         state_nx = IDLE;
         ch_nx    = '0;
         tmr_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx = SETTLE;
               ch_nx    = '0;
               tmr_nx   = '0;
            end
            SETTLE: begin
               if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                  state_nx = GATE;
                  tmr_nx   = '0;
               end else begin
                  tmr_nx = tmr + 1'b1;
               end
            end
            GATE: begin
               if (tmr == TMR_W'(GATE_CYCLES - 1)) begin
                  gate_done = 1'b1;
                  tmr_nx    = '0;
                  if (ch == 2'd2) begin
                     state_nx = CLASSIFY;
                  end else begin
                     ch_nx    = ch + 1'b1;
                     state_nx = SETTLE;
                  end
               end else begin
                  tmr_nx = tmr + 1'b1;
               end
            end
            CLASSIFY: begin
               frame_done = 1'b1;
               state_nx   = SETTLE;
               ch_nx      = '0;
               tmr_nx     = '0;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      filt = (state == IDLE) ? FILT_NONE : filt_code(ch);
   end

   always_comb begin
      cls = classify(32'(hold_r), 32'(hold_g), 32'(hold_b),
                     32'(WTH), 32'(RMAX), 32'(GMAX));
   end

   // run==0 means no candidate history; a white frame or en drop resets it
   always_comb begin
      run_nx  = run;
      last_nx = last;
      col_nx  = col;
      if (!en) begin
         run_nx  = '0;
         last_nx = COLOR_NONE;
         col_nx  = COLOR_NONE;
      end else if (frame_done) begin
         if (cls.white) begin
            run_nx  = '0;
            last_nx = COLOR_NONE;
            col_nx  = COLOR_NONE;
         end else if (cls.hit) begin
            if (cls.col == last && run != '0) begin
               run_nx = (run == RUN_W'(CONFIRM)) ? run : run + 1'b1;
            end else begin
               run_nx = RUN_W'(1);
            end
            last_nx = cls.col;
            if (run_nx == RUN_W'(CONFIRM)) begin
               col_nx = cls.col;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ch         <= '0;
         tmr        <= '0;
         hold_r     <= '0;
         hold_b     <= '0;
         hold_g     <= '0;
         red_cnt    <= '0;
         blue_cnt   <= '0;
         green_cnt  <= '0;
         meas_valid <= 1'b0;
         col        <= COLOR_NONE;
         last       <= COLOR_NONE;
         run        <= '0;
      end else begin
         state      <= state_nx;
         ch         <= ch_nx;
         tmr        <= tmr_nx;
         meas_valid <= frame_done;
         col        <= col_nx;
         last       <= last_nx;
         run        <= run_nx;
         if (gate_done) begin
            case (ch)
               2'd0:    hold_r <= cnt_live;
               2'd1:    hold_b <= cnt_live;
               default: hold_g <= cnt_live;
            endcase
         end
         if (frame_done) begin
            red_cnt   <= hold_r;
            blue_cnt  <= hold_b;
            green_cnt <= hold_g;
         end
      end
   end

endmodule

// File: tb/tb_sm_color_classifier.sv
// Directed bench: a filter-aware sensor model drives dut_a (12-bit, gate 16)
// and a free-running clk/2 source drives dut_b (4-bit, gate 64, saturation).
module tb_sm_color_classifier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en_a, en_b;
   logic        cs_a, cs_b;
   logic        s0_a, s1_a, s2_a, s3_a, oe_a;
   logic        s0_b, s1_b, s2_b, s3_b, oe_b;
   logic [11:0] r_a, b_a, g_a;
   logic [3:0]  r_b, b_b, g_b;
   logic        mv_a, mv_b;
   logic [1:0]  col_a, col_b;

   int per_r, per_g, per_b;
   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   sm_color_classifier #(
      .CNT_W(12), .GATE_CYCLES(16), .SETTLE_CYCLES(2), .CONFIRM(2),
      .WHITE_TH(6), .RED_OTHER_MAX(5), .GB_OTHER_MAX(5)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .cs_out(cs_a),
      .S0(s0_a), .S1(s1_a), .S2(s2_a), .S3(s3_a), .OE(oe_a),
      .red_cnt(r_a), .blue_cnt(b_a), .green_cnt(g_a),
      .meas_valid(mv_a), .color(col_a)
   );

   sm_color_classifier #(
      .CNT_W(4), .GATE_CYCLES(64), .SETTLE_CYCLES(2), .CONFIRM(1),
      .WHITE_TH(14), .RED_OTHER_MAX(5), .GB_OTHER_MAX(5)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .cs_out(cs_b),
      .S0(s0_b), .S1(s1_b), .S2(s2_b), .S3(s3_b), .OE(oe_b),
      .red_cnt(r_b), .blue_cnt(b_b), .green_cnt(g_b),
      .meas_valid(mv_b), .color(col_b)
   );

   // Sensor model: square wave with a per-filter period, phase restarted low
   // on every filter change so each 16-cycle gate sees exactly 16/period edges.
   initial begin
      int         ph;
      int         p;
      logic [1:0] prev_f;
      cs_a   = 1'b0;
      ph     = 0;
      prev_f = 2'b10;
      forever begin
         @(negedge clk);
         if ({s2_a, s3_a} != prev_f) ph = 0;
         else ph++;
         prev_f = {s2_a, s3_a};
         case (prev_f)
            2'b00:   p = per_r;
            2'b01:   p = per_b;
            2'b11:   p = per_g;
            default: p = 0;
         endcase
         cs_a = (p == 0) ? 1'b0 : ((ph % p) >= (p / 2));
      end
   end

   initial begin
      cs_b = 1'b0;
      forever begin
         @(negedge clk);
         cs_b = ~cs_b;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic wait_pulse(input int which, input int limit, output int n);
      logic hit;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         hit = (which == 0) ? mv_a : mv_b;
      end while (!hit && n < limit);
   endtask

   task automatic run_frame(input string tag, input int pr, pg, pb,
                            input int er, eg, eb, input logic [1:0] ecol);
      int n;
      per_r = pr;
      per_g = pg;
      per_b = pb;
      wait_pulse(0, 200, n);
      check_eq({tag, "_period"}, n, 55);
      check_eq({tag, "_red"}, r_a, er);
      check_eq({tag, "_green"}, g_a, eg);
      check_eq({tag, "_blue"}, b_a, eb);
      check_eq({tag, "_color"}, col_a, ecol);
   endtask

   initial begin
      int n;
      int pulses;
      rst_n = 1'b0;
      en_a  = 1'b0;
      en_b  = 1'b0;
      per_r = 4;
      per_g = 4;
      per_b = 4;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_s0", s0_a, 1);
      check_eq("rst_s1", s1_a, 0);
      check_eq("rst_oe", oe_a, 0);
      check_eq("rst_s2s3", {s2_a, s3_a}, 2'b10);
      check_eq("rst_counts", {r_a, g_a, b_a}, 0);
      check_eq("rst_mv", mv_a, 0);
      check_eq("rst_color", col_a, 0);
      check_eq("rst_b_pins", {s0_b, s1_b, oe_b, s2_b, s3_b}, 5'b10010);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      en_a = 1'b1;
      @(posedge clk);
      #1;
      check_eq("red_code", {s2_a, s3_a}, 2'b00);
      wait_pulse(0, 200, n);
      check_eq("first_pulse_lat", n, 55);
      check_eq("uni_red", r_a, 4);
      check_eq("uni_green", g_a, 4);
      check_eq("uni_blue", b_a, 4);
      check_eq("uni_color", col_a, 0);
      @(posedge clk);
      #1;
      check_eq("mv_one_cycle", mv_a, 0);
      per_r = 4;
      wait_pulse(0, 200, n);
      check_eq("uni_period", n + 1, 55);

      run_frame("alt_r1", 2, 8, 8, 8, 2, 2, 2'b00);
      run_frame("alt_b1", 8, 8, 2, 2, 2, 8, 2'b00);
      run_frame("alt_r2", 2, 8, 8, 8, 2, 2, 2'b00);
      run_frame("alt_b2", 8, 8, 2, 2, 2, 8, 2'b00);
      run_frame("red1",   2, 8, 8, 8, 2, 2, 2'b00);
      run_frame("red2",   2, 8, 8, 8, 2, 2, 2'b01);
      run_frame("grn1",   8, 2, 8, 2, 8, 2, 2'b01);
      run_frame("grn2",   8, 2, 8, 2, 8, 2, 2'b11);
      run_frame("tie",    4, 4, 4, 4, 4, 4, 2'b11);
      run_frame("white",  2, 2, 2, 8, 8, 8, 2'b00);
      run_frame("grn3",   8, 2, 8, 2, 8, 2, 2'b00);
      run_frame("grn4",   8, 2, 8, 2, 8, 2, 2'b11);

      repeat (45) @(posedge clk);
      #1;
      check_eq("green_gate_code", {s2_a, s3_a}, 2'b11);
      en_a = 1'b0;
      @(posedge clk);
      #1;
      check_eq("drop_code", {s2_a, s3_a}, 2'b10);
      check_eq("drop_color", col_a, 0);
      check_eq("drop_mv", mv_a, 0);
      pulses = 0;
      for (int i = 0; i < 120; i++) begin
         @(posedge clk);
         #1;
         if (mv_a) pulses++;
      end
      check_eq("drop_no_pulse", pulses, 0);
      check_eq("drop_held_red", r_a, 2);
      check_eq("drop_held_green", g_a, 8);
      per_r = 4;
      per_g = 4;
      per_b = 4;
      en_a  = 1'b1;
      @(posedge clk);
      #1;
      check_eq("reen_red_code", {s2_a, s3_a}, 2'b00);
      wait_pulse(0, 200, n);
      check_eq("reen_pulse_lat", n, 55);
      check_eq("reen_red", r_a, 4);
      check_eq("reen_color", col_a, 0);

      en_b = 1'b1;
      @(posedge clk);
      #1;
      check_eq("b_red_code", {s2_b, s3_b}, 2'b00);
      wait_pulse(1, 400, n);
      check_eq("b_pulse_lat", n, 199);
      check_eq("b_sat_red", r_b, 15);
      check_eq("b_sat_green", g_b, 15);
      check_eq("b_sat_blue", b_b, 15);
      check_eq("b_color", col_b, 0);

      repeat (20) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_red", r_a, 0);
      check_eq("midrst_code", {s2_a, s3_a}, 2'b10);
      check_eq("midrst_b_cnt", r_b, 0);
      check_eq("midrst_mv", mv_a | mv_b, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
